// File: rtl/linear_layer_ctrl_pkg.sv
// Shared control definitions for the linear-layer dataflow sequencers:
// state encoding, counter width helper and default counter width.
package linear_layer_ctrl_pkg;

    localparam int unsigned DEFAULT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int unsigned credit_width(input int unsigned max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/linear_layer_credit_counter.sv
// Up/down in-flight counter with registered full/empty flags; a simultaneous
// inc and dec leaves the count unchanged.
module linear_layer_credit_counter #(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned WIDTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty
);

    logic             dec_eff;
    logic             inc_eff;
    logic [WIDTH-1:0] count_next;

    assign dec_eff = dec && !empty;
    assign inc_eff = inc && (!full || dec_eff);

    always_comb begin
        count_next = count;
        if (inc_eff && !dec_eff) begin
            count_next = count + WIDTH'(1);
        end else if (dec_eff && !inc_eff) begin
            count_next = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == WIDTH'(MAX_COUNT));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/linear_layer_start_token_consumer.sv
// Start-FIFO read-side sequencer driving a consumer ap_start/ap_ready/ap_done port.
// Optional stall counters enabled by LINEAR_LAYER_START_CONSUMER_PERF_EN.
module linear_layer_start_token_consumer
    import linear_layer_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 run_start,
    input  logic [CNT_WIDTH-1:0] iter_total,
    input  logic                 start_if_empty_n,
    output logic                 start_if_read,
    output logic                 proc_ap_start,
    input  logic                 proc_ap_ready,
    input  logic                 proc_ap_done,
    output logic                 busy,
    output logic                 all_done,
    output logic [CNT_WIDTH-1:0] issued_cnt,
    output logic [CNT_WIDTH-1:0] done_cnt,
`ifdef LINEAR_LAYER_START_CONSUMER_PERF_EN
    output logic [CNT_WIDTH-1:0] stall_empty_cycles,
    output logic [CNT_WIDTH-1:0] stall_credit_cycles,
`endif
    output logic                 proto_err
);

    localparam int unsigned OUT_W = credit_width(MAX_OUTSTANDING);

    state_t               state;
    logic [CNT_WIDTH-1:0] total;
    logic [CNT_WIDTH-1:0] issued_next;
    logic [OUT_W-1:0]     outstanding;
    logic                 credit_full;
    logic                 credit_empty;
    logic                 issue_ack;
    logic                 done_ok;
    logic                 done_bad;
    logic                 pop;
    logic                 drain_done;

    assign issue_ack   = (state == ST_ISSUE) && proc_ap_ready;
    assign done_ok     = (state != ST_IDLE) && proc_ap_done && !credit_empty;
    assign done_bad    = proc_ap_done && !done_ok;
    assign pop         = (state == ST_FETCH) && start_if_empty_n &&
                         (issued_cnt < total) && !credit_full;
    assign issued_next = issued_cnt + CNT_WIDTH'(1);
    // A done landing in the same cycle as the last outstanding one still completes the drain.
    assign drain_done  = credit_empty || ((outstanding == OUT_W'(1)) && done_ok);

    assign start_if_read = pop;

    linear_layer_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .WIDTH     (OUT_W)
    ) u_credit (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .inc   (issue_ack),
        .dec   (done_ok),
        .count (outstanding),
        .full  (credit_full),
        .empty (credit_empty)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= ST_IDLE;
            total         <= '0;
            issued_cnt    <= '0;
            done_cnt      <= '0;
            proc_ap_start <= 1'b0;
            busy          <= 1'b0;
            all_done      <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            all_done <= 1'b0;
            if (done_ok) begin
                done_cnt <= done_cnt + CNT_WIDTH'(1);
            end
            if (done_bad) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (run_start) begin
                        total      <= iter_total;
                        issued_cnt <= '0;
                        done_cnt   <= '0;
                        proto_err  <= 1'b0;
                        if (iter_total == '0) begin
                            all_done <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (pop) begin
                        state         <= ST_ISSUE;
                        proc_ap_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (proc_ap_ready) begin
                        proc_ap_start <= 1'b0;
                        issued_cnt    <= issued_next;
                        state         <= (issued_next == total) ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        all_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LINEAR_LAYER_START_CONSUMER_PERF_EN
    // Saturating stall counters, cleared when a run is accepted.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stall_empty_cycles  <= '0;
            stall_credit_cycles <= '0;
        end else if ((state == ST_IDLE) && run_start) begin
            stall_empty_cycles  <= '0;
            stall_credit_cycles <= '0;
        end else if (state == ST_FETCH) begin
            if (!start_if_empty_n && (issued_cnt < total) && (stall_empty_cycles != '1)) begin
                stall_empty_cycles <= stall_empty_cycles + CNT_WIDTH'(1);
            end
            if (credit_full && (stall_credit_cycles != '1)) begin
                stall_credit_cycles <= stall_credit_cycles + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: doc/linear_layer_start_token_consumer.md
Name:
linear_layer_start_token_consumer

Overview:
- Read-side sequencer for a dataflow start-propagation FIFO.
- Pops start tokens that the producer process pushed, and drives the ap_start/ap_ready/ap_done handshake of the downstream consumer process (for example the bias-loop stage).
- Counts issued and completed iterations, bounds in-flight work, and signals run completion.
- Sits between the start FIFO read port and the consumer process control port.

Parameters:
- MAX_OUTSTANDING, 2: maximum number of iterations started but not yet done (>=1).
- CNT_WIDTH, 32: width of the iteration counters and iter_total.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous, active-high reset
- run_start  in  1  one-cycle pulse; latches iter_total and begins a run (accepted only in IDLE)
- iter_total  in  CNT_WIDTH  number of iterations in the run
- start_if_empty_n  in  1  start FIFO has a token
- start_if_read  out  1  pop strobe to the start FIFO
- proc_ap_start  out  1  start to the consumer process
- proc_ap_ready  in  1  consumer accepted the start
- proc_ap_done  in  1  consumer finished one iteration (one-cycle pulse)
- busy  out  1  run in progress
- all_done  out  1  one-cycle pulse when the run completes
- issued_cnt  out  CNT_WIDTH  iterations started in the current run
- done_cnt  out  CNT_WIDTH  iterations completed in the current run
- proto_err  out  1  sticky: proc_ap_done received with zero outstanding

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0; issued_cnt, done_cnt, the outstanding counter and the latched total are all 0.
  - A token already popped before reset is discarded, with no replay.
- States: IDLE, FETCH, ISSUE, DRAIN. All outputs except start_if_read are registered.
- IDLE:
  - busy=0.
  - On run_start, latch iter_total and clear issued_cnt, done_cnt and proto_err.
  - If iter_total==0: all_done pulses next cycle and the state stays IDLE.
  - Otherwise go to FETCH.
- FETCH:
  - Pop condition: start_if_empty_n && issued_cnt<total && outstanding<MAX_OUTSTANDING.
  - start_if_read is combinational and equals the pop condition.
  - On a pop, go to ISSUE.
  - If outstanding==MAX_OUTSTANDING, no pop occurs and the block stays in FETCH.
- ISSUE:
  - proc_ap_start=1 and is held until proc_ap_ready is sampled high.
  - On ready: issued_cnt+1 and outstanding+1.
  - Next state is DRAIN if the new issued_cnt==total, otherwise FETCH.
  - proc_ap_start deasserts the cycle after ready.
- Outstanding counter:
  - Width is clog2(MAX_OUTSTANDING+1).
  - Decrements on proc_ap_done in any non-IDLE state; done_cnt increments with it.
  - Simultaneous ready and done: net outstanding is unchanged, and both counters still increment.
- proc_ap_done while outstanding==0, or in IDLE: ignored for the counters; proto_err is set sticky until the next accepted run_start.
- DRAIN:
  - Wait for outstanding==0, counting a done that arrives in the same cycle.
  - Then pulse all_done for 1 cycle and return to IDLE.
  - busy drops in the same cycle as the all_done pulse.
- run_start outside IDLE: ignored.
- Throughput: at best 1 token per 2 cycles (FETCH pop, then ISSUE with ready in the same cycle).
- Latency: a token visible in FETCH produces proc_ap_start=1 on the next cycle.
- Counters never wrap within a run because total <= 2^CNT_WIDTH-1.

Optional Feature:
- Macro: LINEAR_LAYER_START_CONSUMER_PERF_EN
- Defined:
  - Adds outputs stall_empty_cycles and stall_credit_cycles (CNT_WIDTH each).
  - stall_empty_cycles counts FETCH cycles with start_if_empty_n=0 and issued_cnt<total.
  - stall_credit_cycles counts FETCH cycles blocked by the outstanding limit.
  - Both counters clear on an accepted run_start or ap_rst and saturate at all-ones.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package linear_layer_ctrl_pkg holds:
  - the state enum (IDLE/FETCH/ISSUE/DRAIN) and its 2-bit encoding;
  - a function that computes the outstanding counter width;
  - the default CNT_WIDTH constant.
- One natural sub-module: linear_layer_credit_counter, an up/down outstanding counter with full/empty flags and simultaneous inc/dec handling. It can be reused by the other dataflow sequencers.

Test Plan:
- iter_total=3, FIFO holds 3 tokens, ready tied high, done 2 cycles after each ready -> exactly 3 start_if_read pulses; issued_cnt=3, done_cnt=3; all_done pulses once; proto_err=0.
- iter_total=4, MAX_OUTSTANDING=2, done withheld -> 2 pops, then start_if_read stays 0. Releasing one done gives exactly one further pop.
- FIFO empty for 10 cycles mid-run -> no pop and proc_ap_start stays 0. With PERF_EN, stall_empty_cycles=10.
- proc_ap_ready delayed 5 cycles -> proc_ap_start held for 5 cycles. In the cycle where ready and done coincide, the outstanding count is unchanged.
- proc_ap_done in IDLE -> proto_err=1, counters unchanged. The next run_start clears proto_err.
- iter_total=0 -> all_done pulses 1 cycle after run_start, with no FIFO read. Separately, ap_rst asserted in ISSUE -> next cycle all outputs 0 and the state is IDLE.
